// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - video timing bundle from the sync generator to the pixel mux
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
  );

  modport slave (
    input  p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480 raster timing generator with pixel-rate enable
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int HD       = 640,
  parameter int HF       = 16,
  parameter int HR       = 96,
  parameter int HB       = 48,
  parameter int VD       = 480,
  parameter int VF       = 10,
  parameter int VR       = 2,
  parameter int VB       = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = HD + HF + HR + HB;
  localparam int V_TOTAL = VD + VF + VR + VB;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_LO   = 10'(HD + HF);
  localparam logic [9:0] HS_HI   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_LO   = 10'(VD + VF);
  localparam logic [9:0] VS_HI   = 10'(VD + VF + VR - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       pix_x_q, pix_x_d;
  logic [9:0]       pix_y_q, pix_y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic             p_tick;

  // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so p_tick is constantly high.
  assign p_tick = (div_cnt_q == DIV_LAST);

  // Sync/video flags are computed from the next coordinate so they stay aligned with pix_x/pix_y.
  always_comb begin
    div_cnt_d     = p_tick ? '0 : div_cnt_q + DIV_W'(1);
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (p_tick) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == V_LAST) ? '0 : pix_y_q + 10'd1;
      end else begin
        pix_x_d = pix_x_q + 10'd1;
      end
      video_on_d    = (pix_x_d < 10'(HD)) && (pix_y_d < 10'(VD));
      hsync_d       = ((pix_x_d >= HS_LO) && (pix_x_d <= HS_HI)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((pix_y_d >= VS_LO) && (pix_y_d <= VS_HI)) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = (pix_x_d == '0) && (pix_y_d == '0);
    end
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q     <= '0;
      pix_x_q       <= H_LAST;
      pix_y_q       <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.p_tick      = p_tick;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.video_on    = video_on_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed checks of vga_sync_gen at full and reduced raster sizes
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, rst2_n;

  vga_sync_gen_if if0();
  vga_sync_gen_if if1();
  vga_sync_gen_if if2();

  vga_sync_gen u0 (.clk(clk), .reset_n(rst0_n), .vga(if0));

  vga_sync_gen #(
    .CLK_DIV(1), .HD(8), .HF(2), .HR(3), .HB(1),
    .VD(6), .VF(1), .VR(2), .VB(1), .SYNC_POL(1'b1)
  ) u1 (.clk(clk), .reset_n(rst1_n), .vga(if1));

  vga_sync_gen #(
    .CLK_DIV(2), .HD(8), .HF(2), .HR(3), .HB(1),
    .VD(6), .VF(1), .VR(2), .VB(1), .SYNC_POL(1'b0)
  ) u2 (.clk(clk), .reset_n(rst2_n), .vga(if2));

  typedef struct {
    int         edge_n;
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       fs;
  } vec_t;

  vec_t tbl[17];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, ending on a falling edge for sampling.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int cur_edge;
    int c_pt, c_hs, c_vs, c_vo, c_fs;
    int first_low;

    //            edge  pt  x    y    vo hs vs fs
    tbl[0]  = '{0,    0, 799, 524, 0, 1, 1, 0};
    tbl[1]  = '{2,    0, 799, 524, 0, 1, 1, 0};
    tbl[2]  = '{3,    1, 799, 524, 0, 1, 1, 0};
    tbl[3]  = '{4,    0, 0,   0,   1, 1, 1, 1};
    tbl[4]  = '{5,    0, 0,   0,   1, 1, 1, 0};
    tbl[5]  = '{7,    1, 0,   0,   1, 1, 1, 0};
    tbl[6]  = '{8,    0, 1,   0,   1, 1, 1, 0};
    tbl[7]  = '{2560, 0, 639, 0,   1, 1, 1, 0};
    tbl[8]  = '{2564, 0, 640, 0,   0, 1, 1, 0};
    tbl[9]  = '{2624, 0, 655, 0,   0, 1, 1, 0};
    tbl[10] = '{2628, 0, 656, 0,   0, 0, 1, 0};
    tbl[11] = '{3008, 0, 751, 0,   0, 0, 1, 0};
    tbl[12] = '{3012, 0, 752, 0,   0, 1, 1, 0};
    tbl[13] = '{3200, 0, 799, 0,   0, 1, 1, 0};
    tbl[14] = '{3203, 1, 799, 0,   0, 1, 1, 0};
    tbl[15] = '{3204, 0, 0,   1,   1, 1, 1, 0};
    tbl[16] = '{3206, 0, 0,   1,   1, 1, 1, 0};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);

    // Full-size raster, CLK_DIV=4: reset state, first tick, porch/sync edges
    rst0_n   = 1'b1;
    cur_edge = 0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].edge_n - cur_edge);
      cur_edge = tbl[i].edge_n;
      check($sformatf("v%0d_e%0d_p_tick", i, cur_edge), 32'(if0.p_tick), 32'(tbl[i].pt));
      check($sformatf("v%0d_e%0d_pix_x", i, cur_edge), 32'(if0.pix_x), 32'(tbl[i].x));
      check($sformatf("v%0d_e%0d_pix_y", i, cur_edge), 32'(if0.pix_y), 32'(tbl[i].y));
      check($sformatf("v%0d_e%0d_video_on", i, cur_edge), 32'(if0.video_on), 32'(tbl[i].vo));
      check($sformatf("v%0d_e%0d_hsync", i, cur_edge), 32'(if0.hsync), 32'(tbl[i].hs));
      check($sformatf("v%0d_e%0d_vsync", i, cur_edge), 32'(if0.vsync), 32'(tbl[i].vs));
      check($sformatf("v%0d_e%0d_frame_start", i, cur_edge), 32'(if0.frame_start), 32'(tbl[i].fs));
    end

    // One full line (edges 3207..6406): 800 ticks, 96 sync pixels, 160 blank pixels
    c_pt = 0; c_hs = 0; c_vo = 0;
    for (int i = 0; i < 3200; i++) begin
      step(1);
      if (if0.p_tick)    c_pt++;
      if (!if0.hsync)    c_hs++;
      if (!if0.video_on) c_vo++;
    end
    check("line_p_ticks", 32'(c_pt), 32'd800);
    check("line_hsync_clks", 32'(c_hs), 32'd384);
    check("line_blank_clks", 32'(c_vo), 32'd640);
    check("line_end_x", 32'(if0.pix_x), 32'd0);
    check("line_end_y", 32'(if0.pix_y), 32'd2);

    // Reduced raster, CLK_DIV=1, active-high sync: 14x10 total, 8x6 visible
    check("u1_rst_hsync", 32'(if1.hsync), 32'd0);
    check("u1_rst_vsync", 32'(if1.vsync), 32'd0);
    check("u1_rst_x", 32'(if1.pix_x), 32'd13);
    check("u1_rst_y", 32'(if1.pix_y), 32'd9);
    rst1_n = 1'b1;
    step(1);
    check("u1_first_x", 32'(if1.pix_x), 32'd0);
    check("u1_first_y", 32'(if1.pix_y), 32'd0);
    check("u1_first_fs", 32'(if1.frame_start), 32'd1);
    c_pt = 0; c_hs = 0; c_vs = 0; c_vo = 0; c_fs = 0;
    for (int i = 0; i < 140; i++) begin
      if (i != 0) step(1);
      if (if1.p_tick)      c_pt++;
      if (if1.hsync)       c_hs++;
      if (if1.vsync)       c_vs++;
      if (if1.video_on)    c_vo++;
      if (if1.frame_start) c_fs++;
    end
    check("u1_frame_ticks", 32'(c_pt), 32'd140);
    check("u1_frame_hsync", 32'(c_hs), 32'd30);
    check("u1_frame_vsync", 32'(c_vs), 32'd28);
    check("u1_frame_video", 32'(c_vo), 32'd48);
    check("u1_frame_starts", 32'(c_fs), 32'd1);
    check("u1_last_x", 32'(if1.pix_x), 32'd13);
    check("u1_last_y", 32'(if1.pix_y), 32'd9);
    step(1);
    check("u1_wrap_x", 32'(if1.pix_x), 32'd0);
    check("u1_wrap_y", 32'(if1.pix_y), 32'd0);
    check("u1_wrap_fs", 32'(if1.frame_start), 32'd1);
    step(1);
    check("u1_fs_drop", 32'(if1.frame_start), 32'd0);

    // Reduced raster, CLK_DIV=2: async reset in the middle of an hsync pulse
    rst2_n = 1'b1;
    step(108);
    check("u2_pre_x", 32'(if2.pix_x), 32'd11);
    check("u2_pre_y", 32'(if2.pix_y), 32'd3);
    check("u2_pre_hsync", 32'(if2.hsync), 32'd0);
    @(posedge clk);
    #2 rst2_n = 1'b0;
    #1;
    check("u2_async_x", 32'(if2.pix_x), 32'd13);
    check("u2_async_y", 32'(if2.pix_y), 32'd9);
    check("u2_async_hsync", 32'(if2.hsync), 32'd1);
    check("u2_async_vsync", 32'(if2.vsync), 32'd1);
    check("u2_async_video", 32'(if2.video_on), 32'd0);
    check("u2_async_p_tick", 32'(if2.p_tick), 32'd0);
    @(negedge clk);
    rst2_n    = 1'b1;
    c_hs      = 0;
    first_low = -1;
    for (int e = 1; e <= 28; e++) begin
      step(1);
      if (!if2.hsync) begin
        c_hs++;
        if (first_low < 0) first_low = e;
      end
      if (e == 2) begin
        check("u2_restart_x", 32'(if2.pix_x), 32'd0);
        check("u2_restart_y", 32'(if2.pix_y), 32'd0);
        check("u2_restart_fs", 32'(if2.frame_start), 32'd1);
      end
    end
    check("u2_first_hsync_edge", 32'(first_low), 32'd22);
    check("u2_hsync_clks", 32'(c_hs), 32'd6);
    check("u2_line_end_x", 32'(if2.pix_x), 32'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
